// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   FWD_*      : operand-forwarding select encodings used by the ID-stage muxes
//   REG_PC     : register number of the PC (r15); it is never forwarded
//   hz_state_t : load-use stall FSM states
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [3:0] REG_PC = 4'hF;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// Operand-forwarding select for one ID-stage source operand.
//   src, use_src           : source register number and whether it is read
//   exe_rd/en, mem_rd/en,
//   wb_rd/en               : destination register and write enable per stage
//   sel                    : 00 regfile, 01 EXE, 10 MEM, 11 WB
// The youngest matching producer wins (EXE > MEM > WB). The PC and unused
// sources always read the register file path.
module fwd_select
  import pipe_pkg::*;
(
  input  logic [3:0] src,
  input  logic       use_src,
  input  logic [3:0] exe_rd,
  input  logic       exe_en,
  input  logic [3:0] mem_rd,
  input  logic       mem_en,
  input  logic [3:0] wb_rd,
  input  logic       wb_en,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (use_src && (src != REG_PC)) begin
      if (exe_en && (exe_rd == src))      sel = FWD_EXE;
      else if (mem_en && (mem_rd == src)) sel = FWD_MEM;
      else if (wb_en && (wb_rd == src))   sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the five-stage core.
//   clk, reset (async, active-low)
//   id_rn/rm/rd + id_use_*   : ID-stage sources and their use flags
//   branch_taken             : taken branch resolved in ID
//   exe/mem/wb_rd + *_rf_en  : stage destinations and write enables
//   exe_load                 : EXE instruction is a load
//   pc_le, ifid_le, nop_s    : stall controls (combinational)
//   ifid_flush               : registered IF/ID flush (one cycle after branch)
//   fwd_a/b/c                : forwarding selects for Rn/Rm/Rd
//   stall_count, flush_count : saturating event counters
//   dbg_state, dbg_bc,
//   dbg_lat_rd               : FSM state, bubble counter, latched load rd
// Valid/ready note: there is no handshake here; pc_le/ifid_le low means the
// front end holds its registers for that cycle, nop_s high means ID/EXE
// receives a bubble in the same cycle.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int LOAD_STALLS = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_rn,
  input  logic [3:0]       id_rm,
  input  logic [3:0]       id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic             branch_taken,
  input  logic [3:0]       exe_rd,
  input  logic [3:0]       mem_rd,
  input  logic [3:0]       wb_rd,
  input  logic             exe_rf_en,
  input  logic             mem_rf_en,
  input  logic             wb_rf_en,
  input  logic             exe_load,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             nop_s,
  output logic             ifid_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             dbg_state,
  output logic [2:0]       dbg_bc,
  output logic [3:0]       dbg_lat_rd
);

  hz_state_t        state_q, state_d;
  logic [2:0]       bc_q, bc_d;
  logic [3:0]       lat_rd_q, lat_rd_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hz;
  logic             stall_now;
  logic [1:0]       raw_a, raw_b, raw_c;

  fwd_select u_fwd_a (
    .src(id_rn), .use_src(id_use_rn),
    .exe_rd(exe_rd), .exe_en(exe_rf_en), .mem_rd(mem_rd), .mem_en(mem_rf_en),
    .wb_rd(wb_rd), .wb_en(wb_rf_en), .sel(raw_a)
  );
  fwd_select u_fwd_b (
    .src(id_rm), .use_src(id_use_rm),
    .exe_rd(exe_rd), .exe_en(exe_rf_en), .mem_rd(mem_rd), .mem_en(mem_rf_en),
    .wb_rd(wb_rd), .wb_en(wb_rf_en), .sel(raw_b)
  );
  fwd_select u_fwd_c (
    .src(id_rd), .use_src(id_use_rd),
    .exe_rd(exe_rd), .exe_en(exe_rf_en), .mem_rd(mem_rd), .mem_en(mem_rf_en),
    .wb_rd(wb_rd), .wb_en(wb_rf_en), .sel(raw_c)
  );

  // Combinational outputs are held at their reset values while reset is low.
  assign fwd_a = reset ? raw_a : FWD_RF;
  assign fwd_b = reset ? raw_b : FWD_RF;
  assign fwd_c = reset ? raw_c : FWD_RF;

  // Load-use: the loaded value is only available from MEM onwards.
  assign hz = exe_load && exe_rf_en && (exe_rd != REG_PC) &&
              ((id_use_rn && (id_rn == exe_rd)) ||
               (id_use_rm && (id_rm == exe_rd)) ||
               (id_use_rd && (id_rd == exe_rd)));

  always_comb begin
    state_d   = state_q;
    bc_d      = bc_q;
    lat_rd_d  = lat_rd_q;
    stall_now = 1'b0;
    case (state_q)
      RUN: begin
        if (hz) begin
          stall_now = 1'b1;
          if (LOAD_STALLS > 1) begin
            state_d  = STALL;
            bc_d     = 3'(LOAD_STALLS - 1);
            lat_rd_d = exe_rd;
          end
        end
      end
      STALL: begin
        // Remaining bubbles are committed; the load has left EXE, so the
        // latched rd identifies the hazard until the count runs out.
        stall_now = 1'b1;
        bc_d      = bc_q - 3'd1;
        if (bc_q == 3'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (!reset) stall_now = 1'b0;
  end

  assign pc_le   = ~stall_now;
  assign ifid_le = ~stall_now;
  assign nop_s   = stall_now;

  // A branch seen during a stall stays in ID and is re-evaluated on release.
  assign flush_d = branch_taken & ~stall_now;

  assign stall_cnt_d = (stall_now && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = (flush_q && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      bc_q        <= 3'd0;
      lat_rd_q    <= 4'd0;
      flush_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bc_q        <= bc_d;
      lat_rd_q    <= lat_rd_d;
      flush_q     <= flush_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ifid_flush  = flush_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
  assign dbg_state   = state_q;
  assign dbg_bc      = bc_q;
  assign dbg_lat_rd  = lat_rd_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit. Three instances share one set of inputs:
// u_l1 (LOAD_STALLS=1), u_l3 (LOAD_STALLS=3) and u_sat (LOAD_STALLS=1,
// CNT_W=2) whose narrow counters show saturation.
module tb_hazard_unit;

  logic       clk, reset;
  logic [3:0] id_rn, id_rm, id_rd, exe_rd, mem_rd, wb_rd;
  logic       id_use_rn, id_use_rm, id_use_rd, branch_taken;
  logic       exe_rf_en, mem_rf_en, wb_rf_en, exe_load;

  logic        pc_le_1, ifid_le_1, nop_s_1, flush_1, st_1;
  logic [1:0]  fa_1, fb_1, fc_1;
  logic [15:0] sc_1, fcnt_1;
  logic [2:0]  bc_1;
  logic [3:0]  lr_1;

  logic        pc_le_3, ifid_le_3, nop_s_3, flush_3, st_3;
  logic [1:0]  fa_3, fb_3, fc_3;
  logic [15:0] sc_3, fcnt_3;
  logic [2:0]  bc_3;
  logic [3:0]  lr_3;

  logic        pc_le_s, ifid_le_s, nop_s_s, flush_s, st_s;
  logic [1:0]  fa_s, fb_s, fc_s;
  logic [1:0]  sc_s, fcnt_s;
  logic [2:0]  bc_s;
  logic [3:0]  lr_s;

  int checks = 0;
  int errors = 0;

  hazard_unit #(.LOAD_STALLS(1), .CNT_W(16)) u_l1 (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .branch_taken(branch_taken), .exe_rd(exe_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .exe_rf_en(exe_rf_en), .mem_rf_en(mem_rf_en), .wb_rf_en(wb_rf_en), .exe_load(exe_load),
    .pc_le(pc_le_1), .ifid_le(ifid_le_1), .nop_s(nop_s_1), .ifid_flush(flush_1),
    .fwd_a(fa_1), .fwd_b(fb_1), .fwd_c(fc_1), .stall_count(sc_1), .flush_count(fcnt_1),
    .dbg_state(st_1), .dbg_bc(bc_1), .dbg_lat_rd(lr_1)
  );

  hazard_unit #(.LOAD_STALLS(3), .CNT_W(16)) u_l3 (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .branch_taken(branch_taken), .exe_rd(exe_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .exe_rf_en(exe_rf_en), .mem_rf_en(mem_rf_en), .wb_rf_en(wb_rf_en), .exe_load(exe_load),
    .pc_le(pc_le_3), .ifid_le(ifid_le_3), .nop_s(nop_s_3), .ifid_flush(flush_3),
    .fwd_a(fa_3), .fwd_b(fb_3), .fwd_c(fc_3), .stall_count(sc_3), .flush_count(fcnt_3),
    .dbg_state(st_3), .dbg_bc(bc_3), .dbg_lat_rd(lr_3)
  );

  hazard_unit #(.LOAD_STALLS(1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .branch_taken(branch_taken), .exe_rd(exe_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .exe_rf_en(exe_rf_en), .mem_rf_en(mem_rf_en), .wb_rf_en(wb_rf_en), .exe_load(exe_load),
    .pc_le(pc_le_s), .ifid_le(ifid_le_s), .nop_s(nop_s_s), .ifid_flush(flush_s),
    .fwd_a(fa_s), .fwd_b(fb_s), .fwd_c(fc_s), .stall_count(sc_s), .flush_count(fcnt_s),
    .dbg_state(st_s), .dbg_bc(bc_s), .dbg_lat_rd(lr_s)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rn = 4'd0; id_rm = 4'd0; id_rd = 4'd0;
    id_use_rn = 1'b0; id_use_rm = 1'b0; id_use_rd = 1'b0;
    branch_taken = 1'b0;
    exe_rd = 4'd0; mem_rd = 4'd0; wb_rd = 4'd0;
    exe_rf_en = 1'b0; mem_rf_en = 1'b0; wb_rf_en = 1'b0;
    exe_load = 1'b0;
  endtask

  // Load to r5 in EXE, ID instruction reads r5 as Rm.
  task automatic load_use_hazard();
    exe_load = 1'b1; exe_rf_en = 1'b1; exe_rd = 4'd5;
    id_rm = 4'd5; id_use_rm = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    #12;
    // Reset state
    chk("rst_pc_le", 32'(pc_le_3), 32'd1);
    chk("rst_ifid_le", 32'(ifid_le_3), 32'd1);
    chk("rst_nop_s", 32'(nop_s_3), 32'd0);
    chk("rst_flush", 32'(flush_3), 32'd0);
    chk("rst_state", 32'(st_3), 32'd0);
    chk("rst_lat_rd", 32'(lr_3), 32'd0);
    reset = 1'b1;
    tick();

    // 1: idle after release
    chk("t1_pc_le", 32'(pc_le_1), 32'd1);
    chk("t1_ifid_le", 32'(ifid_le_1), 32'd1);
    chk("t1_nop_s", 32'(nop_s_1), 32'd0);
    chk("t1_fwd", {26'd0, fa_1, fb_1, fc_1}, 32'd0);
    chk("t1_stall_cnt", 32'(sc_1), 32'd0);
    chk("t1_flush_cnt", 32'(fcnt_1), 32'd0);

    // 2: forwarding priority
    id_rn = 4'd3; id_use_rn = 1'b1;
    exe_rd = 4'd3; exe_rf_en = 1'b1; mem_rd = 4'd3; mem_rf_en = 1'b1;
    #1 chk("t2_fwd_exe", 32'(fa_1), 32'b01);
    exe_rf_en = 1'b0;
    #1 chk("t2_fwd_mem", 32'(fa_1), 32'b10);
    wb_rd = 4'd3; wb_rf_en = 1'b1; mem_rf_en = 1'b0;
    #1 chk("t2_fwd_wb", 32'(fa_1), 32'b11);
    id_use_rn = 1'b0;
    #1 chk("t2_fwd_unused", 32'(fa_1), 32'b00);
    id_use_rn = 1'b1; id_rn = 4'hF; exe_rd = 4'hF; exe_rf_en = 1'b1;
    #1 chk("t2_fwd_pc", 32'(fa_1), 32'b00);
    id_rd = 4'd7; id_use_rd = 1'b1; mem_rd = 4'd7; mem_rf_en = 1'b1;
    #1 chk("t2_fwd_c_mem", 32'(fc_1), 32'b10);
    clear_inputs();
    tick();

    // 3/4: single load-use hazard on both stall depths
    load_use_hazard();
    #1;
    chk("t3_pc_le", 32'(pc_le_1), 32'd0);
    chk("t3_ifid_le", 32'(ifid_le_1), 32'd0);
    chk("t3_nop_s", 32'(nop_s_1), 32'd1);
    chk("t4_nop_c1", 32'(nop_s_3), 32'd1);
    tick();
    // Load has moved to MEM
    clear_inputs();
    id_rm = 4'd5; id_use_rm = 1'b1; mem_rd = 4'd5; mem_rf_en = 1'b1;
    #1;
    chk("t3_nop_after", 32'(nop_s_1), 32'd0);
    chk("t3_pc_after", 32'(pc_le_1), 32'd1);
    chk("t3_fwd_b_mem", 32'(fb_1), 32'b10);
    chk("t3_stall_cnt", 32'(sc_1), 32'd1);
    chk("t4_nop_c2", 32'(nop_s_3), 32'd1);
    chk("t4_state_c2", 32'(st_3), 32'd1);
    chk("t4_lat_rd", 32'(lr_3), 32'd5);
    tick();
    chk("t4_nop_c3", 32'(nop_s_3), 32'd1);
    chk("t4_pc_le_c3", 32'(pc_le_3), 32'd0);
    tick();
    chk("t4_nop_c4", 32'(nop_s_3), 32'd0);
    chk("t4_state_run", 32'(st_3), 32'd0);
    chk("t4_stall_cnt", 32'(sc_3), 32'd3);
    chk("t3_stall_cnt_hold", 32'(sc_1), 32'd1);
    clear_inputs();

    // 5a: plain branch
    branch_taken = 1'b1;
    #1 chk("t5_flush_same", 32'(flush_1), 32'd0);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("t5_flush_next", 32'(flush_1), 32'd1);
    chk("t5_flush_cnt_pre", 32'(fcnt_1), 32'd0);
    tick();
    chk("t5_flush_gone", 32'(flush_1), 32'd0);
    chk("t5_flush_cnt", 32'(fcnt_1), 32'd1);

    // 5b: branch coincides with a 3-bubble stall
    branch_taken = 1'b1;
    load_use_hazard();
    tick();
    exe_load = 1'b0; exe_rf_en = 1'b0; exe_rd = 4'd0;
    #1;
    chk("t5b_flush_s1", 32'(flush_3), 32'd0);
    chk("t5b_nop_s1", 32'(nop_s_3), 32'd1);
    tick();
    chk("t5b_flush_s2", 32'(flush_3), 32'd0);
    chk("t5b_l1_flush", 32'(flush_1), 32'd1);
    tick();
    chk("t5b_nop_rel", 32'(nop_s_3), 32'd0);
    chk("t5b_flush_rel", 32'(flush_3), 32'd0);
    tick();
    chk("t5b_flush_one", 32'(flush_3), 32'd1);
    branch_taken = 1'b0;
    tick();
    chk("t5b_flush_end", 32'(flush_3), 32'd0);
    chk("t5b_flush_cnt", 32'(fcnt_3), 32'd2);
    chk("sat_flush_cnt", 32'(fcnt_s), 32'd3);

    // Stall counter saturation on the 2-bit instance
    load_use_hazard();
    tick(); tick(); tick();
    chk("sat_stall_cnt", 32'(sc_s), 32'd3);
    clear_inputs();
    tick(); tick(); tick();
    chk("pre6_state", 32'(st_3), 32'd0);
    chk("pre6_nop", 32'(nop_s_3), 32'd0);

    // 6: reset mid-stall
    load_use_hazard();
    tick();
    clear_inputs();
    #1 chk("t6_in_stall", 32'(nop_s_3), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_nop", 32'(nop_s_3), 32'd0);
    chk("t6_rst_pc_le", 32'(pc_le_3), 32'd1);
    chk("t6_rst_ifid_le", 32'(ifid_le_3), 32'd1);
    chk("t6_rst_state", 32'(st_3), 32'd0);
    chk("t6_rst_bc", 32'(bc_3), 32'd0);
    chk("t6_rst_sc", 32'(sc_3), 32'd0);
    chk("t6_rst_fc", 32'(fcnt_3), 32'd0);
    chk("t6_rst_sat", 32'(sc_s), 32'd0);
    #2 reset = 1'b1;
    tick();
    chk("t6_post_nop", 32'(nop_s_3), 32'd0);
    chk("t6_post_state", 32'(st_3), 32'd0);
    tick();
    chk("t6_post_nop2", 32'(nop_s_3), 32'd0);
    chk("t6_post_sc", 32'(sc_3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
